// File: rtl/composition_if_ctrl.sv
// "if" composition sequencer: runs a condition unit, then the YES or NO unit,
// and returns the selected unit's result, with a per-phase watchdog.
module composition_if_ctrl #(
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ST,
  output logic         RD,
  output logic [W-1:0] RES,
  output logic         ERR,
  input  logic [W-1:0] IN1,
  input  logic [W-1:0] IN2,
  input  logic [W-1:0] IN3,
  output logic [W-1:0] OP1,
  output logic [W-1:0] OP2,
  output logic [W-1:0] OP3,
  output logic         C_ST,
  input  logic         C_RD,
  input  logic [W-1:0] C_RES,
  output logic         Y_ST,
  input  logic         Y_RD,
  input  logic [W-1:0] Y_RES,
  output logic         N_ST,
  input  logic         N_RD,
  input  logic [W-1:0] N_RES
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CGO   = 3'd1;
  localparam logic [2:0] S_CACK  = 3'd2;
  localparam logic [2:0] S_CWAIT = 3'd3;
  localparam logic [2:0] S_BGO   = 3'd4;
  localparam logic [2:0] S_BACK  = 3'd5;
  localparam logic [2:0] S_BWAIT = 3'd6;

  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  logic [2:0]   state;
  logic [15:0]  cnt;
  logic         sel;
  logic         c_nz;
  logic         b_rd;
  logic [W-1:0] b_res;
  logic         tmo;

  assign c_nz  = (C_RES != '0);
  assign b_rd  = sel ? Y_RD : N_RD;
  assign b_res = sel ? Y_RES : N_RES;
  assign tmo   = (cnt == TLIM);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      sel   <= 1'b0;
      RD    <= 1'b1;
      RES   <= '0;
      ERR   <= 1'b0;
      OP1   <= '0;
      OP2   <= '0;
      OP3   <= '0;
      C_ST  <= 1'b0;
      Y_ST  <= 1'b0;
      N_ST  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ST && RD) begin
            OP1   <= IN1;
            OP2   <= IN2;
            OP3   <= IN3;
            RD    <= 1'b0;
            ERR   <= 1'b0;
            C_ST  <= 1'b1;
            state <= S_CGO;
          end
        end
        S_CGO: begin
          C_ST  <= 1'b0;
          cnt   <= '0;
          state <= S_CACK;
        end
        S_CACK: begin
          cnt <= cnt + 16'd1;
          // C_RD is still high from before the start; wait for it to drop
          if (!C_RD) begin
            state <= S_CWAIT;
          end else if (tmo) begin
            RES   <= '0;
            ERR   <= 1'b1;
            RD    <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_CWAIT: begin
          cnt <= cnt + 16'd1;
          if (C_RD) begin
            sel   <= c_nz;
            Y_ST  <= c_nz;
            N_ST  <= !c_nz;
            state <= S_BGO;
          end else if (tmo) begin
            RES   <= '0;
            ERR   <= 1'b1;
            RD    <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_BGO: begin
          Y_ST  <= 1'b0;
          N_ST  <= 1'b0;
          cnt   <= '0;
          state <= S_BACK;
        end
        S_BACK: begin
          cnt <= cnt + 16'd1;
          if (!b_rd) begin
            state <= S_BWAIT;
          end else if (tmo) begin
            RES   <= '0;
            ERR   <= 1'b1;
            RD    <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_BWAIT: begin
          cnt <= cnt + 16'd1;
          if (b_rd) begin
            RES   <= b_res;
            RD    <= 1'b1;
            state <= S_IDLE;
          end else if (tmo) begin
            RES   <= '0;
            ERR   <= 1'b1;
            RD    <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/composition_if_ctrl.md
Name: composition_if_ctrl

Overview:
- Initiator-side sequencer for the ST/RD/RES function-unit handshake; implements the "if" composition.
- Accepts a request on its own callee-style ST/RD port, then drives a condition unit's ST and waits on its RD.
- If RES_C is non-zero it starts the YES unit, otherwise the NO unit. It returns that unit's result.
- A watchdog ends the operation with ERR if a sub-unit never completes.

Parameters:
- W, 16, data width of operands and results.
- TIMEOUT, 64, maximum cycles spent in one sub-unit's ACK+WAIT phases before abort (1..65535).

Ports:
- CLK  in  1  clock, all logic on posedge.
- RST  in  1  synchronous reset, active-high.
- ST  in  1  start request, sampled only when RD==1.
- RD  out  1  1 = idle/result valid, 0 = busy.
- RES  out  W  result; valid while RD==1.
- ERR  out  1  1 = last operation aborted by timeout; valid while RD==1.
- IN1, IN2, IN3  in  W each  operands, sampled on accepted ST.
- OP1, OP2, OP3  out  W each  latched operands, shared by all three sub-units.
- C_ST  out  1  start for condition unit.
- C_RD  in  1  ready from condition unit.
- C_RES  in  W  result from condition unit.
- Y_ST  out  1  start for YES unit.
- Y_RD  in  1  ready from YES unit.
- Y_RES  in  W  result from YES unit.
- N_ST  out  1  start for NO unit.
- N_RD  in  1  ready from NO unit.
- N_RES  in  W  result from NO unit.

Behaviour:
- All outputs registered. Reset values:
  - RD=1; RES=0; ERR=0.
  - C_ST=Y_ST=N_ST=0; OP1..OP3=0.
  - state=IDLE; timeout counter=0; branch flag SEL=0.
- RST mid-operation aborts immediately with the same values. No partial result is kept. Sub-unit ST outputs drop at that edge.
- States: IDLE, C_GO, C_ACK, C_WAIT, B_GO, B_ACK, B_WAIT.
- IDLE:
  - If ST==1 and RD==1: latch IN1..IN3 into OP1..OP3; RD<=0; ERR<=0; C_ST<=1; go to C_GO.
  - ST while RD==0 is ignored in every state.
- C_GO: exactly one cycle. C_ST<=0, counter<=0, go to C_ACK.
- C_ACK:
  - If C_RD==0, go to C_WAIT.
  - This state ignores the stale RD=1 left over from before the start.
- C_WAIT:
  - If C_RD==1: SEL <= (C_RES != 0), with all W bits compared.
  - If SEL is 1, Y_ST<=1; otherwise N_ST<=1. Go to B_GO.
- B_GO: one cycle. Drop Y_ST/N_ST, counter<=0, go to B_ACK.
- B_ACK: wait for the selected RD (Y_RD if SEL else N_RD) ==0, then go to B_WAIT.
- B_WAIT:
  - On selected RD==1: RES<=selected RES, RD<=1, go to IDLE.
  - The unselected unit's RD/RES are ignored throughout.
- Timeout:
  - The counter increments each cycle in the ACK/WAIT states.
  - When it reaches TIMEOUT-1 without the exit condition: RES<=0, ERR<=1, RD<=1, go to IDLE.
  - The sub-unit's ST is already low at that point.
- Never more than one of C_ST/Y_ST/N_ST is high. Each is high for exactly one cycle per operation.
- OP1..OP3 hold stable from acceptance until the next accepted ST.
- RES/ERR hold until the next accepted ST.
- Latency, with sub-units that drop RD one edge after ST and raise it 3 edges later (CNT=2 style):
  - RD returns to 1 at the 10th posedge after the edge that accepted ST.
  - RES is valid in that same cycle.
- A start in the same cycle RD rises is not possible (RD is registered). The earliest new start is accepted on the edge after RD==1 is visible.

Test Plan:
- Reset, then idle 5 cycles -> RD=1, RES=0, ERR=0, all *_ST=0, OP*=0.
- IN=(3,4,5), C_RES=1, Y_RES=0x1234, N_RES=0xBEEF, 2-cycle-busy models:
  - C_ST pulses once; OP*=(3,4,5) until done.
  - Y_ST pulses once; N_ST stays 0.
  - RD=1 at 10th edge with RES=0x1234, ERR=0.
- C_RES=0x8000 -> YES branch taken. C_RES=0 -> N_ST pulses, RES=0xBEEF, Y_ST never asserted.
- TIMEOUT=8, YES model never raises Y_RD -> RD=1, ERR=1, RES=0 exactly 8 cycles after B_GO. The next start clears ERR.
- ST held high during busy, then RST asserted mid-C_WAIT:
  - No restart while busy.
  - After RST: RD=1, RES=0, state IDLE.
  - A fresh ST completes normally.
- Back-to-back: ST asserted continuously with alternating C_RES -> each operation completes with the correct branch result. RD is high for at least one cycle between operations.
